fft_stage_sequencer: RTL and testbench



---
 rtl/fft_stage_sequencer.sv | 171 +++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Purpose: sequences an in-place radix-2 DIT FFT through one external butterfly unit.
// Latency: READ, LATCH, ISSUE(>=1), WAIT(>=1), WRITE per butterfly; one butterfly in flight.
// Backpressure: bf_valid and operands hold in ISSUE until bf_ready; WAIT holds until bf_res_valid.
module fft_stage_sequencer #(
    parameter int SIZE  = 64,
    parameter int LOG2N = 6,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    input  logic [DW-1:0]    rd_ra,
    input  logic [DW-1:0]    rd_ia,
    input  logic [DW-1:0]    rd_rb,
    input  logic [DW-1:0]    rd_ib,
    output logic [LOG2N-2:0] tw_addr,
    input  logic [DW-1:0]    tw_cos,
    input  logic [DW-1:0]    tw_sin,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [DW-1:0]    bf_r1,
    output logic [DW-1:0]    bf_i1,
    output logic [DW-1:0]    bf_r2,
    output logic [DW-1:0]    bf_i2,
    output logic [DW-1:0]    bf_cos,
    output logic [DW-1:0]    bf_sin,
    input  logic             bf_res_valid,
    input  logic [DW-1:0]    bf_f0r,
    input  logic [DW-1:0]    bf_f0i,
    input  logic [DW-1:0]    bf_f1r,
    input  logic [DW-1:0]    bf_f1i,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [DW-1:0]    wr_ra,
    output logic [DW-1:0]    wr_ia,
    output logic [DW-1:0]    wr_rb,
    output logic [DW-1:0]    wr_ib
);

    localparam int KW = LOG2N - 1;
    localparam int SW = $clog2(LOG2N);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LATCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t          state, state_nx;
    logic [KW-1:0]   k;
    logic [SW-1:0]   s;
    logic [KW-1:0]   mask_k;
    logic [KW-1:0]   j_k;
    logic [KW-1:0]   tw_idx;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic            last_k;
    logic            last_s;

    // Pair addresses and twiddle index: the low s bits of k select j, the rest
    // select the group, which is spread to a stride of 2*half by one left shift.
    always_comb begin
        mask_k = ~({KW{1'b1}} << s);
        j_k    = k & mask_k;
        addr_a = {k & ~mask_k, 1'b0} | {1'b0, j_k};
        addr_b = addr_a | (LOG2N'(1) << s);
        tw_idx = j_k << (KW - int'(s));
        last_k = (k == KW'(SIZE / 2 - 1));
        last_s = (s == SW'(LOG2N - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: one butterfly at a time, handshakes only honoured in their own state.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_READ;
            S_READ:  state_nx = S_LATCH;
            S_LATCH: state_nx = S_ISSUE;
            S_ISSUE: if (bf_ready) state_nx = S_WAIT;
            S_WAIT:  if (bf_res_valid) state_nx = S_WRITE;
            S_WRITE: state_nx = (last_k && last_s) ? S_DONE : S_READ;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state; addresses are forced to zero outside their strobe state.
    always_comb begin
        busy      = (state == S_READ) || (state == S_LATCH) || (state == S_ISSUE) ||
                    (state == S_WAIT) || (state == S_WRITE);
        done      = (state == S_DONE);
        bf_valid  = (state == S_ISSUE);
        wr_en     = (state == S_WRITE);
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_addr   = '0;
        wr_addr_a = '0;
        wr_addr_b = '0;
        if (state == S_READ) begin
            rd_addr_a = addr_a;
            rd_addr_b = addr_b;
            tw_addr   = tw_idx;
        end
        if (state == S_WRITE) begin
            wr_addr_a = addr_a;
            wr_addr_b = addr_b;
        end
    end

    // Counters, operand capture after the synchronous reads, result capture in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            k      <= '0;
            s      <= '0;
            bf_r1  <= '0;
            bf_i1  <= '0;
            bf_r2  <= '0;
            bf_i2  <= '0;
            bf_cos <= '0;
            bf_sin <= '0;
            wr_ra  <= '0;
            wr_ia  <= '0;
            wr_rb  <= '0;
            wr_ib  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k <= '0;
                        s <= '0;
                    end
                end
                S_LATCH: begin
                    bf_r1  <= rd_ra;
                    bf_i1  <= rd_ia;
                    bf_r2  <= rd_rb;
                    bf_i2  <= rd_ib;
                    bf_cos <= tw_cos;
                    bf_sin <= tw_sin;
                end
                S_WAIT: begin
                    if (bf_res_valid) begin
                        wr_ra <= bf_f0r;
                        wr_ia <= bf_f0i;
                        wr_rb <= bf_f1r;
                        wr_ib <= bf_f1i;
                    end
                end
                S_WRITE: begin
                    if (last_k) begin
                        k <= '0;
                        s <= last_s ? '0 : s + 1'b1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench: SIZE=8 instance with a configurable butterfly model and a
// SIZE=64 instance with a plain loopback butterfly; RAM compared to a DIT reference.
module tb_fft_stage_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- SIZE=8 instance signals ----------------
    logic        start, busy, done, bf_valid, bf_ready, bf_res_valid, wr_en;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0]  tw_addr;
    logic [31:0] rd_ra, rd_ia, rd_rb, rd_ib, tw_cos, tw_sin;
    logic [31:0] bf_r1, bf_i1, bf_r2, bf_i2, bf_cos, bf_sin;
    logic [31:0] bf_f0r, bf_f0i, bf_f1r, bf_f1i, wr_ra, wr_ia, wr_rb, wr_ib;

    // ---------------- SIZE=64 instance signals ----------------
    logic        g_start, g_busy, g_done, g_valid, g_ready, g_res_valid, g_wr_en;
    logic [5:0]  g_rd_a, g_rd_b, g_wr_a, g_wr_b;
    logic [4:0]  g_tw;
    logic [31:0] g_ra, g_ia, g_rb, g_ib, g_cos, g_sin;
    logic [31:0] g_r1, g_i1, g_r2, g_i2, g_bcos, g_bsin;
    logic [31:0] g_f0r, g_f0i, g_f1r, g_f1i, g_wra, g_wia, g_wrb, g_wib;

    fft_stage_sequencer #(.SIZE(8), .LOG2N(3), .DW(32)) u8 (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_ra(rd_ra), .rd_ia(rd_ia), .rd_rb(rd_rb), .rd_ib(rd_ib),
        .tw_addr(tw_addr), .tw_cos(tw_cos), .tw_sin(tw_sin),
        .bf_valid(bf_valid), .bf_ready(bf_ready),
        .bf_r1(bf_r1), .bf_i1(bf_i1), .bf_r2(bf_r2), .bf_i2(bf_i2),
        .bf_cos(bf_cos), .bf_sin(bf_sin),
        .bf_res_valid(bf_res_valid),
        .bf_f0r(bf_f0r), .bf_f0i(bf_f0i), .bf_f1r(bf_f1r), .bf_f1i(bf_f1i),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .wr_ra(wr_ra), .wr_ia(wr_ia), .wr_rb(wr_rb), .wr_ib(wr_ib)
    );

    fft_stage_sequencer #(.SIZE(64), .LOG2N(6), .DW(32)) u64 (
        .clk(clk), .rst(rst), .start(g_start), .busy(g_busy), .done(g_done),
        .rd_addr_a(g_rd_a), .rd_addr_b(g_rd_b),
        .rd_ra(g_ra), .rd_ia(g_ia), .rd_rb(g_rb), .rd_ib(g_ib),
        .tw_addr(g_tw), .tw_cos(g_cos), .tw_sin(g_sin),
        .bf_valid(g_valid), .bf_ready(g_ready),
        .bf_r1(g_r1), .bf_i1(g_i1), .bf_r2(g_r2), .bf_i2(g_i2),
        .bf_cos(g_bcos), .bf_sin(g_bsin),
        .bf_res_valid(g_res_valid),
        .bf_f0r(g_f0r), .bf_f0i(g_f0i), .bf_f1r(g_f1r), .bf_f1i(g_f1i),
        .wr_en(g_wr_en), .wr_addr_a(g_wr_a), .wr_addr_b(g_wr_b),
        .wr_ra(g_wra), .wr_ia(g_wia), .wr_rb(g_wrb), .wr_ib(g_wib)
    );

    int ntests = 0;
    int nfail  = 0;

    // Memories, reference arrays, expected pair/twiddle sequence for SIZE=8.
    logic [31:0] mr [8];
    logic [31:0] mi [8];
    logic [31:0] gr [64];
    logic [31:0] gi [64];
    logic [31:0] rr [64];
    logic [31:0] ri [64];
    int exp_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_t [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    // SIZE=8 RAM (1-cycle read, write at the clock edge) and twiddle ROM.
    always @(posedge clk) begin
        rd_ra  <= mr[rd_addr_a];
        rd_ia  <= mi[rd_addr_a];
        rd_rb  <= mr[rd_addr_b];
        rd_ib  <= mi[rd_addr_b];
        tw_cos <= 32'hC000 + 32'(tw_addr);
        tw_sin <= 32'h5000 + 32'(tw_addr);
        if (wr_en) begin
            mr[wr_addr_a] = wr_ra;
            mi[wr_addr_a] = wr_ia;
            mr[wr_addr_b] = wr_rb;
            mi[wr_addr_b] = wr_ib;
        end
    end

    // SIZE=64 RAM and ROM.
    always @(posedge clk) begin
        g_ra  <= gr[g_rd_a];
        g_ia  <= gi[g_rd_a];
        g_rb  <= gr[g_rd_b];
        g_ib  <= gi[g_rd_b];
        g_cos <= 32'hC000 + 32'(g_tw);
        g_sin <= 32'h5000 + 32'(g_tw);
        if (g_wr_en) begin
            gr[g_wr_a] = g_wra;
            gi[g_wr_a] = g_wia;
            gr[g_wr_b] = g_wrb;
            gi[g_wr_b] = g_wib;
        end
    end

    // SIZE=8 butterfly model and monitor, evaluated on the falling edge.
    int stall_n = 0, res_delay = 1;
    bit spur = 1'b0;
    int vcnt = 0, pcnt = 0;
    bit pend = 1'b0;
    logic [31:0] cr1, ci1, cr2, ci2;
    int busy_cnt, done_cnt, wr_cnt, lcnt, unstable, tw_err;
    int la [64];
    int lb [64];
    int lt [64];
    bit pbusy = 1'b0, pwr = 1'b0, pvld = 1'b0;
    logic [191:0] pops;

    always @(negedge clk) begin
        // monitor
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (wr_en) wr_cnt++;
        if (busy && (!pbusy || pwr) && lcnt < 64) begin
            la[lcnt] = int'(rd_addr_a);
            lb[lcnt] = int'(rd_addr_b);
            lt[lcnt] = int'(tw_addr);
            lcnt++;
        end
        if (bf_valid && pvld && {bf_r1, bf_i1, bf_r2, bf_i2, bf_cos, bf_sin} !== pops) unstable++;
        pbusy = busy;
        pwr   = wr_en;
        pvld  = bf_valid;
        pops  = {bf_r1, bf_i1, bf_r2, bf_i2, bf_cos, bf_sin};
        // butterfly model
        if (rst) begin
            pend = 1'b0; vcnt = 0; bf_ready = 1'b0; bf_res_valid = 1'b0;
        end else begin
            if (pend) begin
                pcnt++;
                if (pcnt >= res_delay) begin
                    bf_res_valid = 1'b1;
                    bf_f0r = cr1 + cr2; bf_f0i = ci1 + ci2;
                    bf_f1r = cr1 - cr2; bf_f1i = ci1 - ci2;
                    pend = 1'b0;
                end else begin
                    bf_res_valid = 1'b0;
                end
            end else if (spur) begin
                bf_res_valid = 1'b1;
                bf_f0r = 32'hBAD0; bf_f0i = 32'hBAD1; bf_f1r = 32'hBAD2; bf_f1i = 32'hBAD3;
            end else begin
                bf_res_valid = 1'b0;
            end
            if (bf_valid) begin
                if (vcnt >= stall_n) begin
                    bf_ready = 1'b1; vcnt = 0; pend = 1'b1; pcnt = 0;
                    cr1 = bf_r1; ci1 = bf_i1; cr2 = bf_r2; ci2 = bf_i2;
                    if (lcnt > 0 && (bf_cos !== 32'hC000 + 32'(lt[lcnt-1]) ||
                                     bf_sin !== 32'h5000 + 32'(lt[lcnt-1]))) tw_err++;
                end else begin
                    bf_ready = 1'b0; vcnt++;
                end
            end else begin
                bf_ready = 1'b0;
            end
        end
    end

    // SIZE=64 loopback butterfly: always ready, result one cycle after the handshake.
    bit gpend = 1'b0;
    logic [31:0] gr1, gi1, gr2, gi2;
    int g_busy_cnt;
    always @(negedge clk) begin
        if (g_busy) g_busy_cnt++;
        if (rst) begin
            gpend = 1'b0; g_ready = 1'b0; g_res_valid = 1'b0;
        end else begin
            if (gpend) begin
                g_res_valid = 1'b1;
                g_f0r = gr1 + gr2; g_f0i = gi1 + gi2;
                g_f1r = gr1 - gr2; g_f1i = gi1 - gi2;
                gpend = 1'b0;
            end else begin
                g_res_valid = 1'b0;
            end
            g_ready = g_valid;
            if (g_valid) begin
                gpend = 1'b1;
                gr1 = g_r1; gi1 = g_i1; gr2 = g_r2; gi2 = g_i2;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        busy_cnt = 0; done_cnt = 0; wr_cnt = 0; lcnt = 0; unstable = 0; tw_err = 0;
    endtask

    task automatic init_ram8();
        for (int i = 0; i < 8; i++) begin
            mr[i] = 32'(i * 7 + 3);
            mi[i] = 32'(100 - i * 5);
            rr[i] = mr[i];
            ri[i] = mi[i];
        end
    endtask

    // Textbook in-place DIT loops with the integer loopback butterfly.
    task automatic ref_fft(input int n);
        logic [31:0] tr, ti;
        for (int half = 1; half < n; half = half * 2)
            for (int st = 0; st < n; st = st + 2 * half)
                for (int j = 0; j < half; j++) begin
                    tr = rr[st + j];
                    ti = ri[st + j];
                    rr[st + j] = tr + rr[st + j + half];
                    ri[st + j] = ti + ri[st + j + half];
                    rr[st + j + half] = tr - rr[st + j + half];
                    ri[st + j + half] = ti - ri[st + j + half];
                end
    endtask

    task automatic check_ram8(input string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_ram%0d", tag, i), {mr[i], mi[i]}, {rr[i], ri[i]});
    endtask

    task automatic wait_done(input string tag, input int limit);
        int c;
        c = 0;
        while (done !== 1'b1 && c < limit) begin
            step(1);
            c++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        int c, gerr;
        rst = 1'b1; start = 1'b0; g_start = 1'b0;
        step(3);
        check("reset_ctl", {busy, done, bf_valid, wr_en}, 0);
        check("reset_addr", {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b}, 0);
        check("reset_data", bf_r1 | bf_i1 | bf_r2 | bf_i2 | bf_cos | bf_sin |
                            wr_ra | wr_ia | wr_rb | wr_ib, 0);
        rst = 1'b0;
        step(2);
        check("idle_no_start", {busy, done}, 0);

        // Basic run: ready always, result one cycle after handshake.
        init_ram8(); clear_stats();
        pulse_start();
        wait_done("t1", 200);
        step(1);
        check("t1_busy", busy_cnt, 60);
        check("t1_done_pulse", {done_cnt, 31'd0, done}, {32'd1, 32'd0});
        check("t1_wr_cnt", wr_cnt, 12);
        check("t1_tw_data", tw_err, 0);
        check("t1_nseq", lcnt, 12);
        for (int e = 0; e < 12; e++)
            check($sformatf("t1_seq%0d", e), {16'(la[e]), 16'(lb[e]), 16'(lt[e])},
                  {16'(exp_a[e]), 16'(exp_b[e]), 16'(exp_t[e])});
        ref_fft(8);
        check_ram8("t1");

        // bf_ready low for 3 cycles per request.
        stall_n = 3;
        init_ram8(); clear_stats();
        pulse_start();
        wait_done("t2", 400);
        step(1);
        check("t2_busy", busy_cnt, 96);
        check("t2_stable", unstable, 0);
        check("t2_wr_cnt", wr_cnt, 12);
        ref_fft(8);
        check_ram8("t2");
        stall_n = 0;

        // Spurious results in IDLE and ISSUE; real result takes 2 WAIT cycles.
        spur = 1'b1; res_delay = 2;
        init_ram8(); clear_stats();
        step(5);
        check("t3_idle_spur", {busy, 31'd0, wr_cnt}, 0);
        pulse_start();
        wait_done("t3", 400);
        step(1);
        check("t3_busy", busy_cnt, 72);
        check("t3_wr_cnt", wr_cnt, 12);
        ref_fft(8);
        check_ram8("t3");
        spur = 1'b0; res_delay = 1;

        // Reset during stage 1, butterfly 2.
        init_ram8(); clear_stats();
        pulse_start();
        c = 0;
        while (lcnt < 7 && c < 100) begin
            step(1);
            c++;
        end
        check("t4_reach_bf", {16'(la[6]), 16'(lb[6]), 16'(lt[6])}, {16'd4, 16'd6, 16'd0});
        rst = 1'b1;
        step(1);
        check("t4_rst_ctl", {busy, done, bf_valid, wr_en}, 0);
        check("t4_rst_addr", {rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b}, 0);
        check("t4_rst_data", bf_r1 | bf_r2 | bf_cos | wr_ra | wr_rb, 0);
        rst = 1'b0;
        step(20);
        check("t4_no_done", {busy, 31'd0, done_cnt}, 0);
        init_ram8(); clear_stats();
        pulse_start();
        wait_done("t4b", 200);
        step(1);
        check("t4_rerun_busy", busy_cnt, 60);
        ref_fft(8);
        check_ram8("t4");

        // start held through DONE, extra start pulses while busy.
        init_ram8(); clear_stats();
        start = 1'b1;
        wait_done("t5a", 200);
        check("t5a_busy", busy_cnt, 60);
        busy_cnt = 0;
        step(1);
        check("t5_idle_gap", {busy, done}, 0);
        step(1);
        check("t5_restart", {busy, rd_addr_a, rd_addr_b}, {1'b1, 3'd0, 3'd1});
        start = 1'b0;
        step(10);
        start = 1'b1; step(1); start = 1'b0;
        step(15);
        start = 1'b1; step(2); start = 1'b0;
        wait_done("t5b", 200);
        step(6);
        check("t5b_busy", busy_cnt, 60);
        check("t5_quiet", {busy, 31'd0, done_cnt}, {1'b0, 31'd0, 32'd2});
        ref_fft(8);
        ref_fft(8);
        check_ram8("t5");

        // SIZE=64 loopback.
        for (int i = 0; i < 64; i++) begin
            gr[i] = 32'(i * 13 + 1);
            gi[i] = 32'(i * i - 40);
            rr[i] = gr[i];
            ri[i] = gi[i];
        end
        g_busy_cnt = 0;
        g_start = 1'b1; step(1); g_start = 1'b0;
        c = 0;
        while (g_done !== 1'b1 && c < 3000) begin
            step(1);
            c++;
        end
        check("t6_done_seen", 64'(g_done), 64'd1);
        step(1);
        check("t6_busy", g_busy_cnt, 960);
        ref_fft(64);
        gerr = 0;
        for (int i = 0; i < 64; i++)
            if ({gr[i], gi[i]} !== {rr[i], ri[i]}) gerr++;
        check("t6_ram_errs", gerr, 0);
        check("t6_ram0", {gr[0], gi[0]}, {rr[0], ri[0]});
        check("t6_ram63", {gr[63], gi[63]}, {rr[63], ri[63]});

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
